// File: rtl/mem_arbiter.sv
// Two-port line arbiter: an instruction-cache read port and a data-cache
// read/write port share one physical memory port, with tie alternation.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,

  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,

  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } grant_e;

  state_e r_state;
  state_e w_next_state;
  grant_e r_last_grant;
  logic   w_req_i;
  logic   w_req_d;

  assign w_req_i = i_read;
  assign w_req_d = d_read | d_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_D;
    end else begin
      r_state <= w_next_state;
      if (pmem_resp && (r_state == GRANT_I)) begin
        r_last_grant <= LAST_I;
      end else if (pmem_resp && (r_state == GRANT_D)) begin
        r_last_grant <= LAST_D;
      end
    end
  end

  // NOTE: next state defaults to the current state before the case, so no
  // path through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) begin
          w_next_state = (r_last_grant == LAST_D) ? GRANT_I : GRANT_D;
        end else if (w_req_i) begin
          w_next_state = GRANT_I;
        end else if (w_req_d) begin
          w_next_state = GRANT_D;
        end
      end
      // A dropped request does not end a grant; only the memory can.
      GRANT_I: if (pmem_resp) w_next_state = DONE;
      GRANT_D: if (pmem_resp) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 256'd0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (r_state)
      GRANT_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      GRANT_D: begin
        // Write wins when a client raises both strobes.
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low; the ports are named clk and rst, with rst low meaning reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 i_read  input  1  instruction-cache line read request; the I-side is read-only.
REQ-005 i_address  input  32  I-side line address; bits [4:0] are forwarded unchanged.
REQ-006 i_rdata  output  256  line data to the I-side; equals pmem_rdata.
REQ-007 i_resp  output  1  one-cycle completion pulse to the I-side.
REQ-008 d_read, d_write  input  1 each  data-cache line read and write requests.
REQ-009 d_address  input  32  D-side line address.
REQ-010 d_wdata  input  256  D-side write line.
REQ-011 d_rdata  output  256  line data to the D-side; equals pmem_rdata.
REQ-012 d_resp  output  1  one-cycle completion pulse to the D-side.
REQ-013 pmem_read, pmem_write  output  1 each  physical memory commands.
REQ-014 pmem_address  output  32  address of the granted requester.
REQ-015 pmem_wdata  output  256  d_wdata while D is granted, else 0.
REQ-016 pmem_rdata  input  256  memory read line.
REQ-017 pmem_resp  input  1  memory completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D and DONE, held in registers.
REQ-019 A requester SHALL hold its request and its inputs stable until its resp; the arbiter does not latch address or data.
REQ-020 In IDLE, all pmem_* commands SHALL be 0 and the FSM SHALL sample requests, where req_i = i_read and req_d = d_read | d_write.
- One request pending: the FSM grants that requester on the next edge.
- Both pending: the FSM grants the requester that was not granted last, per the last_grant register (reset value D, so I wins the first tie).
- No request: the FSM stays in IDLE.
REQ-021 In GRANT_I, outputs SHALL be pmem_read=1, pmem_write=0, pmem_address=i_address.
REQ-022 In GRANT_D, outputs SHALL be pmem_write=d_write, pmem_read=d_read & ~d_write, pmem_address=d_address; if both d_read and d_write are asserted, write takes precedence.
REQ-023 In a grant state, pmem_resp=1 SHALL drive the granted side's resp=1 combinationally in the same cycle, drive the other side's resp=0, and move the FSM to DONE.
REQ-024 The grant SHALL be updated into last_grant on the same edge as REQ-023.
REQ-025 DONE SHALL last exactly one cycle with all pmem_* commands 0, then return to IDLE; this gives the requester one cycle to drop or renew its request.
REQ-026 Access latency SHALL be as follows:
- A request first seen in IDLE at cycle N drives pmem_* commands from cycle N+1.
- The minimum back-to-back turnaround between grants is 2 idle cycles (DONE, then IDLE).
REQ-027 A request deasserted mid-grant (protocol violation) SHALL NOT end the grant early; the FSM waits for pmem_resp.
REQ-028 pmem_resp arriving in IDLE or DONE SHALL be ignored, with no resp pulse and no state change.
REQ-029 i_rdata and d_rdata SHALL both mirror pmem_rdata at all times; only the resp signals qualify the data.
REQ-030 No starvation SHALL occur: with both sides requesting continuously, grants strictly alternate I, D, I, D, and so on.
REQ-031 i_resp and d_resp SHALL never both be 1 in the same cycle.

Reset
REQ-032 On rst=0, asynchronously: state=IDLE, last_grant=D, all pmem_* outputs 0, i_resp=0, d_resp=0.
REQ-033 Reset asserted during GRANT_I or GRANT_D SHALL abort the transaction with no resp pulse; after rst returns high, arbitration restarts in IDLE.
REQ-034 The first clock edge after rst deasserts SHALL be an IDLE sampling edge.

Verification
REQ-035 Scenario: i_read=1, i_address=0x6000_0000 from reset, pmem_resp on the 3rd cycle of GRANT_I.
- Required: pmem_read=1 and pmem_address=0x6000_0000 from cycle 1.
- Required: i_resp=1 for exactly one cycle with i_rdata=pmem_rdata; d_resp stays 0.
REQ-036 Scenario: i_read and d_read both asserted at reset exit, both held continuously.
- Required: grant order I, D, I, D.
- Required: each grant is preceded by DONE/IDLE, and no requester gets two consecutive grants.
REQ-037 Scenario: D write with d_address=0x1234_5660 and d_wdata=all 0xA5 bytes.
- Required: pmem_write=1, pmem_read=0, and pmem_wdata=all 0xA5 bytes.
- Required: d_resp is a single pulse in the cycle pmem_resp=1.
REQ-038 Scenario: d_read and d_write both 1.
- Required: pmem_write=1 and pmem_read=0 throughout GRANT_D.
REQ-039 Scenario: rst pulled low mid-GRANT_D, then released with i_read=1.
- Required: all outputs are 0 immediately and no d_resp pulse occurs.
- Required: the next grant is I.
REQ-040 Scenario: pmem_resp pulsed while in IDLE with no requests.
- Required: no resp pulse occurs and state remains IDLE.
